// File: rtl/adder_meas_pkg.sv
// Shared types and default widths for the adder ring-oscillator measurement blocks.
package adder_meas_pkg;

  localparam int COUNT_W_DEF = 32;
  localparam int GATE_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    DONE
  } meas_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous ring input into the clock domain and flags its rising edges.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse per synchronised low-to-high transition.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ring_edge_counter.sv
// Counts ring-oscillator rising edges over a programmable gate window of clock cycles.
module ring_edge_counter
  import adder_meas_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               ring_in,
  input  logic               start,
  input  logic               abort,
  input  logic [GATE_W-1:0]  gate_cycles,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  meas_state_t       state_q, state_d;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] remaining;
  logic              rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .sig_in  (ring_in),
    .rise    (rise)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (abort) state_d = IDLE;
               else if (start) state_d = ARM;
      ARM:     if (abort) state_d = IDLE;
               else if (gate_q == '0) state_d = DONE;
               else state_d = COUNT;
      COUNT:   if (abort) state_d = IDLE;
               else if (remaining == GATE_W'(1)) state_d = DONE;
      DONE:    if (abort) state_d = IDLE;
               else if (start) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      remaining <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE, DONE: if (start && !abort) gate_q <= gate_cycles;
        ARM: begin
          count     <= '0;
          overflow  <= 1'b0;
          remaining <= gate_q;
        end
        COUNT: begin
          if (abort) begin
            count    <= '0;
            overflow <= 1'b0;
          end else begin
            remaining <= remaining - GATE_W'(1);
            // Saturate rather than wrap; overflow stays set until the next ARM.
            if (rise) begin
              if (count == CNT_MAX) overflow <= 1'b1;
              else count <= count + COUNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ARM) || (state_q == COUNT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_ring_edge_counter.sv
// Scoreboard bench: expected results queued at start, checked when done rises.
module tb_ring_edge_counter;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ring;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] gate = '0;

  logic        busy, done, ovf;
  logic [31:0] count;
  logic        busy4, done4, ovf4;
  logic [3:0]  count4;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  exp_t e_m, e4_m;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int rperiod = 0;
  int rc      = 0;

  ring_edge_counter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ring_in(ring), .start(start), .abort(abort),
    .gate_cycles(gate), .busy(busy), .done(done), .count(count), .overflow(ovf)
  );

  ring_edge_counter #(.COUNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ring_in(ring), .start(start4), .abort(abort),
    .gate_cycles(gate), .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ring: high for the first half of each period, held low when period is 0.
  always @(posedge clk) begin
    #1;
    if (rperiod == 0) ring = 1'b0;
    else ring = ((rc % rperiod) < (rperiod / 2));
    rc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  logic done_q = 1'b0, done4_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) chk("spurious_done", 64'(done), 0);
      else begin
        e_m = exp_q.pop_front();
        chk("done_cyc", 64'(cyc), 64'(e_m.cyc));
        chk("count", 64'(count), 64'(e_m.cnt));
        chk("overflow", 64'(ovf), 64'(e_m.ovf));
      end
    end
    if (done4 && !done4_q) begin
      if (exp4_q.size() == 0) chk("spurious_done4", 64'(done4), 0);
      else begin
        e4_m = exp4_q.pop_front();
        chk("done4_cyc", 64'(cyc), 64'(e4_m.cyc));
        chk("count4", 64'(count4), 64'(e4_m.cnt));
        chk("overflow4", 64'(ovf4), 64'(e4_m.ovf));
      end
    end
    done_q  <= done;
    done4_q <= done4;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start in cycle t; returns in cycle t+1 (ARM).
  task automatic go(input logic [31:0] g, input bit on4, output int t);
    @(posedge clk);
    #1;
    gate   = g;
    start  = 1'b1;
    start4 = on4;
    t      = cyc;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic push(input int c, input logic [31:0] n, input logic o);
    exp_t e;
    e.cyc = c; e.cnt = n; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic push4(input int c, input logic [31:0] n, input logic o);
    exp_t e;
    e.cyc = c; e.cnt = n; e.ovf = o;
    exp4_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drain", 64'(exp_q.size() + exp4_q.size()), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_count"}, 64'(count), 0);
    chk({tag, "_ovf"}, 64'(ovf), 0);
  endtask

  initial begin
    int t;
    tick(3);
    chk_idle("rst");
    chk("rst_count4", 64'(count4), 0);
    rst = 1'b0;
    tick(2);
    chk_idle("post_rst");

    // Period 4, G=100
    rperiod = 4;
    tick(10);
    go(100, 1'b0, t);
    push(t + 102, 25, 1'b0);
    chk("arm_busy", 64'(busy), 1);
    wait_empty(200);

    // Zero gate
    go(0, 1'b0, t);
    push(t + 2, 0, 1'b0);
    chk("zg_busy1", 64'(busy), 1);
    tick(1);
    chk("zg_busy2", 64'(busy), 0);
    chk("zg_done", 64'(done), 1);
    wait_empty(20);

    // Saturation on both widths
    rperiod = 2;
    tick(6);
    go(100, 1'b1, t);
    push(t + 102, 50, 1'b0);
    push4(t + 102, 15, 1'b1);
    wait_empty(200);

    // Abort at start+20
    rperiod = 4;
    tick(6);
    go(100, 1'b0, t);
    tick(19);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk_idle("abort");
    tick(110);
    chk("abort_no_done", 64'(done), 0);

    // start and abort together in IDLE
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 0);

    // Second start during COUNT must be ignored
    go(48, 1'b0, t);
    push(t + 50, 12, 1'b0);
    tick(9);
    gate  = 5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_busy", 64'(busy), 1);
    wait_empty(100);

    // Reset mid-COUNT
    go(100, 1'b0, t);
    tick(30);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    rperiod = 0;
    tick(3);
    rst = 1'b0;
    tick(2);
    go(8, 1'b0, t);
    push(t + 10, 0, 1'b0);
    wait_empty(40);

    // Back-to-back from DONE
    rperiod = 4;
    tick(6);
    go(40, 1'b0, t);
    push(t + 42, 10, 1'b0);
    chk("b2b_busy", 64'(busy), 1);
    chk("b2b_done", 64'(done), 0);
    chk("b2b_count", 64'(count), 0);
    wait_empty(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
